alu_uart_frontend: RTL and testbench
====================================

Name: alu_uart_frontend

Overview:
- Front end that drives the EX-stage ALU from a byte stream and returns its result.
- Collects three bytes from the UART receiver in order: operand1, operand2, opcode. Presents them on registered outputs to the combinational ALU.
- Latches the ALU result and streams it back to the UART transmitter, one byte at a time, MSB byte first.
- Sits between the UART RX/TX blocks and the ALU in the TP3 top level.

Parameters:
- NB_OP, 6, opcode width driven to the ALU.
- NB_DATA, 8, operand width; equals the UART byte width.
- NB_OUT, 16, ALU result width. Must be a multiple of 8; result is sent as NB_OUT/8 bytes.

Ports:
- i_clk  input  1  system clock; all logic rising-edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_rx_data  input  8  byte from UART receiver; valid when i_rx_done is high.
- i_rx_done  input  1  one-cycle strobe: new byte on i_rx_data.
- i_tx_done  input  1  one-cycle strobe: transmitter finished the current byte.
- i_alu_result  input  NB_OUT  combinational result from the ALU.
- o_operand1  output  NB_DATA  registered operand1 to the ALU.
- o_operand2  output  NB_DATA  registered operand2 to the ALU.
- o_opcode  output  NB_OP  registered opcode to the ALU.
- o_tx_data  output  8  byte to the transmitter; held stable from the o_tx_start pulse until i_tx_done.
- o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
- o_busy  output  1  high from the CAPTURE state until the last TX byte completes.

Behaviour:
- Reset: synchronous, active-low. When i_reset_n = 0 at a clock edge:
  - state goes to WAIT_OP1;
  - o_operand1, o_operand2, o_opcode, o_tx_data and the result register clear to 0;
  - o_tx_start = 0, o_busy = 0, byte index = 0.
  - Reset mid-frame or mid-TX aborts immediately. No pending byte is sent after reset.
- States and transitions:
  - WAIT_OP1: on i_rx_done, o_operand1 <= i_rx_data, go to WAIT_OP2.
  - WAIT_OP2: on i_rx_done, o_operand2 <= i_rx_data, go to WAIT_OPC.
  - WAIT_OPC: on i_rx_done, o_opcode <= i_rx_data[NB_OP-1:0] (upper bits discarded), go to CAPTURE.
  - CAPTURE: one cycle. Result register <= i_alu_result; byte index <= NB_OUT/8-1; go to SEND.
    - The ALU has settled because its inputs were registered the previous edge.
  - SEND: o_tx_data <= result byte[index]; o_tx_start pulses high for exactly the next cycle; go to WAIT_TX.
  - WAIT_TX: hold o_tx_data until i_tx_done.
    - If index = 0, go to WAIT_OP1.
    - Otherwise decrement index and go to SEND.
- Latency: the first o_tx_start is asserted 3 cycles after the cycle in which the opcode's i_rx_done is sampled.
- Opcode values are not validated. Undefined opcodes pass through and the ALU default result (0) is returned.
- i_rx_done outside the WAIT_* states (CAPTURE, SEND, WAIT_TX) is ignored; that byte is dropped, not queued.
- i_tx_done outside WAIT_TX is ignored.
- i_tx_done arriving in the same cycle as o_tx_start is not accepted for the new byte.
- No timeout: WAIT_TX stalls indefinitely until i_tx_done.
- Operand and opcode outputs hold their values until overwritten by the next frame. The ALU output therefore stays stable during TX.
- o_tx_start is never high for two consecutive cycles.

Decomposition:
- Shared package holds:
  - state enum: WAIT_OP1, WAIT_OP2, WAIT_OPC, CAPTURE, SEND, WAIT_TX;
  - ALU opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111.
  - Both the ALU and the bench use this package.
- No sub-module. The byte serializer is a few lines inside the FSM. The ALU is instantiated beside this block at top level, not inside it.

Test Plan:
- ADD: RX 0x05, 0x03, 0x20 -> o_operand1 = 0x05, o_operand2 = 0x03, o_opcode = 0x20; TX bytes 0x00 then 0x08; o_busy falls after the second i_tx_done.
- SUB negative: RX 0x03, 0x05, 0x22 -> result 0xFFFE; TX 0xFF then 0xFE.
- SRA: RX 0x80, 0x02, 0x03 -> TX 0xFF, 0xE0. Then RX a 4th byte 0x55 during WAIT_TX -> dropped; the next frame starts clean.
- TX stall: hold i_tx_done low 1000 cycles after the first o_tx_start -> o_tx_data stable at the MSB byte, no extra o_tx_start pulses.
- Reset mid-frame: RX 0x05, 0x03, then i_reset_n = 0 for 1 cycle -> all outputs 0, state WAIT_OP1. Next RX 0x02, 0x02, 0x20 -> TX 0x00, 0x04.
- Undefined opcode: RX 0x0F, 0xF0, 0x3F -> TX 0x00, 0x00; opcode upper bits from RX 0xE0 are masked to 0x20.

Source files
------------

// File: rtl/alu_uart_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_frontend_pkg
// Description : Shared FSM state encoding and ALU opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_uart_frontend_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_OP1 = 3'd0,
        ST_WAIT_OP2 = 3'd1,
        ST_WAIT_OPC = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_TX  = 3'd5
    } state_t;

    localparam logic [5:0] c_OP_ADD = 6'b100000;
    localparam logic [5:0] c_OP_SUB = 6'b100010;
    localparam logic [5:0] c_OP_AND = 6'b100100;
    localparam logic [5:0] c_OP_OR  = 6'b100101;
    localparam logic [5:0] c_OP_XOR = 6'b100110;
    localparam logic [5:0] c_OP_SRA = 6'b000011;
    localparam logic [5:0] c_OP_SRL = 6'b000010;
    localparam logic [5:0] c_OP_NOR = 6'b100111;

endpackage
`default_nettype wire

// File: rtl/alu_uart_frontend.sv
`default_nettype none
// ============================================================================
// Module      : alu_uart_frontend
// Description : Collects operand1/operand2/opcode bytes for the ALU and
//               streams the latched result back to the UART, MSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_uart_frontend
    import alu_uart_frontend_pkg::*;
#(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 8,
    parameter int NB_OUT  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    input  logic [NB_OUT-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]  o_operand1,
    output logic [NB_DATA-1:0]  o_operand2,
    output logic [NB_OP-1:0]    o_opcode,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy
);

    localparam int c_NBYTES = NB_OUT / 8;
    localparam int NB_IDX   = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam logic [NB_IDX-1:0] c_IDX_LAST = NB_IDX'(c_NBYTES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [NB_DATA-1:0]  r_operand1;
    logic [NB_DATA-1:0]  r_operand2;
    logic [NB_OP-1:0]    r_opcode;
    logic [NB_OUT-1:0]   r_result;
    logic [NB_IDX-1:0]   r_idx;
    logic [7:0]          r_tx_data;
    logic                r_tx_start;
    logic                w_tx_ack;
    logic [7:0]          w_tx_byte;

    // A done strobe coincident with the start pulse belongs to the previous byte.
    assign w_tx_ack  = i_tx_done && !r_tx_start;
    assign w_tx_byte = r_result[{r_idx, 3'b000} +: 8];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_WAIT_OP1;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_OP1: if (i_rx_done) w_state_next = ST_WAIT_OP2;
            ST_WAIT_OP2: if (i_rx_done) w_state_next = ST_WAIT_OPC;
            ST_WAIT_OPC: if (i_rx_done) w_state_next = ST_CAPTURE;
            ST_CAPTURE:  w_state_next = ST_SEND;
            ST_SEND:     w_state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (w_tx_ack) begin
                    w_state_next = (r_idx == '0) ? ST_WAIT_OP1 : ST_SEND;
                end
            end
            default:     w_state_next = ST_WAIT_OP1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_operand1 <= '0;
            r_operand2 <= '0;
            r_opcode   <= '0;
            r_result   <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_WAIT_OP1: if (i_rx_done) r_operand1 <= i_rx_data;
                ST_WAIT_OP2: if (i_rx_done) r_operand2 <= i_rx_data;
                ST_WAIT_OPC: if (i_rx_done) r_opcode   <= i_rx_data[NB_OP-1:0];
                ST_CAPTURE: begin
                    r_result <= i_alu_result;
                    r_idx    <= c_IDX_LAST;
                end
                ST_SEND: begin
                    r_tx_data  <= w_tx_byte;
                    r_tx_start <= 1'b1;
                end
                ST_WAIT_TX: begin
                    if (w_tx_ack && (r_idx != '0)) begin
                        r_idx <= r_idx - NB_IDX'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_operand1 = r_operand1;
    assign o_operand2 = r_operand2;
    assign o_opcode   = r_opcode;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = (r_state == ST_CAPTURE) || (r_state == ST_SEND) ||
                        (r_state == ST_WAIT_TX);

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_uart_frontend
// Description : Scoreboard bench: frames in over RX, result bytes checked on TX.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_uart_frontend;
    import alu_uart_frontend_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic [15:0] alu_result;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [5:0]  opcode;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;

    int          passed;
    int          total;
    logic [7:0]  exp_q[$];

    alu_uart_frontend #(.NB_OP(6), .NB_DATA(8), .NB_OUT(16)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_operand1   (operand1),
        .o_operand2   (operand2),
        .o_opcode     (opcode),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU standing beside the front end: operands are sign-extended to 16 bits.
    always_comb begin
        logic signed [15:0] a;
        logic signed [15:0] b;
        a = {{8{operand1[7]}}, operand1};
        b = {{8{operand2[7]}}, operand2};
        case (opcode)
            c_OP_ADD: alu_result = a + b;
            c_OP_SUB: alu_result = a - b;
            c_OP_AND: alu_result = a & b;
            c_OP_OR:  alu_result = a | b;
            c_OP_XOR: alu_result = a ^ b;
            c_OP_NOR: alu_result = ~(a | b);
            c_OP_SRA: alu_result = a >>> operand2;
            c_OP_SRL: alu_result = {8'h00, operand1} >> operand2;
            default:  alu_result = 16'h0000;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        rx_byte(a);
        tick();
        rx_byte(b);
        tick();
        rx_byte(op);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!tx_start && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (tx_start !== 1'b1) $display("FAIL start_timeout: tx_start=%b after %0d cycles, required 1", tx_start, n);
        else passed++;
    endtask

    // Receives n bytes, holding tx_done low for hold cycles each; optional RX noise on byte 0.
    task automatic get_bytes(input int n, input int hold, input bit inject_rx);
        logic [7:0] exp;
        logic [7:0] held;
        bit         bad;
        for (int i = 0; i < n; i++) begin
            wait_start();
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++;
            if (tx_data !== exp) $display("FAIL tx_byte%0d: got %h required %h", i, tx_data, exp);
            else passed++;
            total++;
            if (busy !== 1'b1) $display("FAIL busy_tx%0d: got %b required 1", i, busy);
            else passed++;
            held = tx_data;
            bad  = 1'b0;
            tick();
            if (inject_rx && i == 0) rx_byte(8'h55);
            for (int k = 0; k < hold; k++) begin
                if (tx_start !== 1'b0 || tx_data !== held) bad = 1'b1;
                tick();
            end
            if (tx_start !== 1'b0 || tx_data !== held) bad = 1'b1;
            total++;
            if (bad) $display("FAIL tx_hold%0d: start/data moved while waiting, data=%h required %h", i, tx_data, held);
            else passed++;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        total++;
        if (busy !== 1'b0) $display("FAIL busy_end: got %b required 0", busy);
        else passed++;
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if ({operand1, operand2, opcode, tx_data, tx_start, busy} !== 32'h0)
            $display("FAIL %s: op1=%h op2=%h opc=%h txd=%h start=%b busy=%b, required all 0",
                     tag, operand1, operand2, opcode, tx_data, tx_start, busy);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        send_frame(8'h05, 8'h03, 8'h20);
        total++;
        if ({operand1, operand2, opcode} !== {8'h05, 8'h03, 6'h20})
            $display("FAIL add_operands: got %h %h %h required 05 03 20", operand1, operand2, opcode);
        else passed++;
        total++;
        if (busy !== 1'b1 || tx_start !== 1'b0) $display("FAIL capture_busy: busy=%b start=%b required 1 0", busy, tx_start);
        else passed++;
        tick();
        total++;
        if (tx_start !== 1'b0) $display("FAIL latency_early: start=%b required 0", tx_start);
        else passed++;
        tick();
        total++;
        if (tx_start !== 1'b1) $display("FAIL latency: start=%b required 1", tx_start);
        else passed++;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        get_bytes(2, 3, 1'b0);
    endtask

    task automatic test_sub();
        send_frame(8'h03, 8'h05, 8'h22);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        get_bytes(2, 2, 1'b0);
    endtask

    task automatic test_sra_drop();
        send_frame(8'h80, 8'h02, 8'h03);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hE0);
        get_bytes(2, 4, 1'b1);
        tick();
        send_frame(8'h01, 8'h02, 8'hE0);
        total++;
        if ({operand1, operand2, opcode} !== {8'h01, 8'h02, 6'h20})
            $display("FAIL clean_frame: got %h %h %h required 01 02 20", operand1, operand2, opcode);
        else passed++;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        get_bytes(2, 1, 1'b0);
    endtask

    task automatic test_stall();
        send_frame(8'h07, 8'h01, 8'h20);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h08);
        get_bytes(2, 1000, 1'b0);
    endtask

    task automatic test_done_same_cycle();
        bit bad;
        send_frame(8'h01, 8'h01, 8'h20);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        wait_start();
        total++;
        if (tx_data !== exp_q[0]) $display("FAIL same_cycle_byte0: got %h required %h", tx_data, exp_q[0]);
        else passed++;
        void'(exp_q.pop_front());
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b1) bad = 1'b1;
            tick();
        end
        total++;
        if (bad) $display("FAIL same_cycle_done: start=%b data=%h busy=%b required 0 00 1", tx_start, tx_data, busy);
        else passed++;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        get_bytes(1, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit bad;
        rx_byte(8'h05);
        tick();
        rx_byte(8'h03);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle_outputs("reset_mid_frame");
        send_frame(8'h02, 8'h02, 8'h20);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        get_bytes(2, 1, 1'b0);
        send_frame(8'h09, 8'h09, 8'h20);
        wait_start();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        total++;
        if (bad) $display("FAIL reset_mid_tx: start=%b busy=%b required 0 0", tx_start, busy);
        else passed++;
        check_idle_outputs("reset_mid_tx_outputs");
    endtask

    task automatic test_undef();
        send_frame(8'h0F, 8'hF0, 8'h3F);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        get_bytes(2, 1, 1'b0);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_sra_drop();
        test_stall();
        test_done_same_cycle();
        test_reset_mid();
        test_undef();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
